// File: rtl/dijkstra_core.sv
// Single-source Dijkstra over a dense weight matrix read one cell per cycle.
// Define DIJKSTRA_DIST_OUT_EN to expose the internal distance array as dist_vector.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 8
`endif

module dijkstra_core #(
   parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
   parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
   parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [INDEX_WIDTH-1:0] source_node,
   input  logic [INDEX_WIDTH-1:0] number_of_nodes,
   output logic [INDEX_WIDTH-1:0] weight_row,
   output logic [INDEX_WIDTH-1:0] weight_col,
   output logic                   weight_read_enable,
   input  logic [VALUE_WIDTH-1:0] weight_data,
   output logic                   ready,
   output logic [INDEX_WIDTH-1:0] prev_vector [0:MAX_NODES-1]
`ifdef DIJKSTRA_DIST_OUT_EN
   ,
   output logic [VALUE_WIDTH-1:0] dist_vector [0:MAX_NODES-1]
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SELECT,
      S_RELAX,
      S_DONE
   } state_t;

   localparam logic [VALUE_WIDTH-1:0] INF = '1;

   state_t r_state;
   state_t w_next;

   logic [INDEX_WIDTH-1:0] r_src;
   logic [INDEX_WIDTH-1:0] r_n;
   logic [INDEX_WIDTH-1:0] r_cnt;
   logic [INDEX_WIDTH-1:0] r_u;
   logic [INDEX_WIDTH-1:0] r_nvis;
   logic [INDEX_WIDTH-1:0] r_min_idx;
   logic [VALUE_WIDTH-1:0] r_min_val;
   logic [VALUE_WIDTH-1:0] r_dist [0:MAX_NODES-1];
   logic [INDEX_WIDTH-1:0] r_prev [0:MAX_NODES-1];
   logic [MAX_NODES-1:0]   r_visited;

   logic                   w_err;
   logic                   w_last_sel;
   logic                   w_last_rlx;
   logic [INDEX_WIDTH-1:0] w_v;
   logic [VALUE_WIDTH-1:0] w_dist_cnt;
   logic                   w_vis_cnt;
   logic [VALUE_WIDTH-1:0] w_dist_u;
   logic [VALUE_WIDTH-1:0] w_dist_v;
   logic                   w_vis_v;
   logic                   w_take;
   logic [INDEX_WIDTH-1:0] w_sel_idx;
   logic [VALUE_WIDTH-1:0] w_sel_val;
   logic                   w_sel_none;
   logic [VALUE_WIDTH:0]   w_cand;
   logic                   w_upd;

   assign w_err = (r_n == '0)
      || (r_n > INDEX_WIDTH'(MAX_NODES))
      || (r_src >= r_n);
   assign w_last_sel = (r_cnt == r_n - 1'b1);
   assign w_last_rlx = (r_cnt == r_n);
   // Response arriving this cycle belongs to the column strobed last cycle
   assign w_v = r_cnt - 1'b1;

   always_comb begin
      w_dist_cnt = INF;
      w_vis_cnt  = 1'b1;
      w_dist_u   = INF;
      w_dist_v   = INF;
      w_vis_v    = 1'b1;
      for (int i = 0; i < MAX_NODES; i++) begin
         if (INDEX_WIDTH'(i) == r_cnt) begin
            w_dist_cnt = r_dist[i];
            w_vis_cnt  = r_visited[i];
         end
         if (INDEX_WIDTH'(i) == r_u) begin
            w_dist_u = r_dist[i];
         end
         if (INDEX_WIDTH'(i) == w_v) begin
            w_dist_v = r_dist[i];
            w_vis_v  = r_visited[i];
         end
      end
   end

   assign w_take     = !w_vis_cnt && (w_dist_cnt < r_min_val);
   assign w_sel_idx  = w_take ? r_cnt : r_min_idx;
   assign w_sel_val  = w_take ? w_dist_cnt : r_min_val;
   assign w_sel_none = (w_sel_val == INF);

   // Extra carry bit lets overflow saturate instead of wrapping
   assign w_cand = {1'b0, w_dist_u} + {1'b0, weight_data};
   assign w_upd  = (r_cnt != '0)
      && (weight_data != '0)
      && !w_vis_v
      && (w_v != r_u)
      && !w_cand[VALUE_WIDTH]
      && (w_cand[VALUE_WIDTH-1:0] != INF)
      && (w_cand[VALUE_WIDTH-1:0] < w_dist_v);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next             = r_state;
      weight_read_enable = 1'b0;
      weight_row         = '0;
      weight_col         = '0;
      ready              = (r_state == S_DONE);
      if (!enable) begin
         w_next = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:   w_next = S_INIT;
            S_INIT:   w_next = w_err ? S_DONE : S_SELECT;
            S_SELECT: begin
               if (w_last_sel) begin
                  w_next = w_sel_none ? S_DONE : S_RELAX;
               end
            end
            S_RELAX: begin
               if (w_last_rlx) begin
                  w_next = (r_nvis == r_n) ? S_DONE : S_SELECT;
               end
            end
            S_DONE:   w_next = S_DONE;
            default:  w_next = S_IDLE;
         endcase
      end
      if (r_state == S_RELAX && !w_last_rlx) begin
         weight_read_enable = 1'b1;
         weight_row         = r_u;
         weight_col         = r_cnt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_src     <= '0;
         r_n       <= '0;
         r_cnt     <= '0;
         r_u       <= '0;
         r_nvis    <= '0;
         r_min_idx <= '0;
         r_min_val <= INF;
         r_visited <= '0;
         for (int i = 0; i < MAX_NODES; i++) begin
            r_dist[i] <= INF;
            r_prev[i] <= INDEX_WIDTH'(i);
         end
      end else if (!enable) begin
         r_src     <= '0;
         r_n       <= '0;
         r_cnt     <= '0;
         r_u       <= '0;
         r_nvis    <= '0;
         r_min_idx <= '0;
         r_min_val <= INF;
         r_visited <= '0;
         for (int i = 0; i < MAX_NODES; i++) begin
            r_dist[i] <= INF;
            r_prev[i] <= INDEX_WIDTH'(i);
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_src <= source_node;
               r_n   <= number_of_nodes;
            end
            S_INIT: begin
               r_cnt     <= '0;
               r_min_val <= INF;
               r_min_idx <= '0;
               if (!w_err) begin
                  for (int i = 0; i < MAX_NODES; i++) begin
                     if (INDEX_WIDTH'(i) == r_src) begin
                        r_dist[i] <= '0;
                     end
                  end
               end
            end
            S_SELECT: begin
               if (w_last_sel) begin
                  r_cnt     <= '0;
                  r_min_val <= INF;
                  r_min_idx <= '0;
                  if (!w_sel_none) begin
                     r_u    <= w_sel_idx;
                     r_nvis <= r_nvis + 1'b1;
                     for (int i = 0; i < MAX_NODES; i++) begin
                        if (INDEX_WIDTH'(i) == w_sel_idx) begin
                           r_visited[i] <= 1'b1;
                        end
                     end
                  end
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
                  r_min_val <= w_sel_val;
                  r_min_idx <= w_sel_idx;
               end
            end
            S_RELAX: begin
               r_cnt <= w_last_rlx ? '0 : r_cnt + 1'b1;
               for (int i = 0; i < MAX_NODES; i++) begin
                  if (w_upd && INDEX_WIDTH'(i) == w_v) begin
                     r_dist[i] <= w_cand[VALUE_WIDTH-1:0];
                     r_prev[i] <= r_u;
                  end
               end
            end
            S_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   assign prev_vector = r_prev;

`ifdef DIJKSTRA_DIST_OUT_EN
   assign dist_vector = r_dist;
`endif

endmodule

// File: tb/tb_dijkstra_core.sv
// Bench for dijkstra_core: directed graphs, abort, async reset, random graphs
// checked against a plain array-based Dijkstra model.
module tb_dijkstra_core;

   localparam int MN  = 8;
   localparam int IW  = 4;
   localparam int VW  = 8;
   localparam int INF = 255;

   logic          clock = 1'b0;
   logic          reset;
   logic          enable;
   logic [IW-1:0] source_node;
   logic [IW-1:0] number_of_nodes;
   logic [IW-1:0] weight_row;
   logic [IW-1:0] weight_col;
   logic          weight_read_enable;
   logic [VW-1:0] weight_data = '0;
   logic          ready;
   logic [IW-1:0] prev_vector [0:MN-1];
`ifdef DIJKSTRA_DIST_OUT_EN
   logic [VW-1:0] dist_vector [0:MN-1];
`endif

   int w [MN][MN];
   int exp_prev [MN];
   int exp_dist [MN];
   int vectors = 0;
   int miscompares = 0;
   int cur_n = MN;

   dijkstra_core #(
      .MAX_NODES(MN),
      .INDEX_WIDTH(IW),
      .VALUE_WIDTH(VW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .source_node(source_node),
      .number_of_nodes(number_of_nodes),
      .weight_row(weight_row),
      .weight_col(weight_col),
      .weight_read_enable(weight_read_enable),
      .weight_data(weight_data),
      .ready(ready),
      .prev_vector(prev_vector)
`ifdef DIJKSTRA_DIST_OUT_EN
      ,
      .dist_vector(dist_vector)
`endif
   );

   always #5 clock = ~clock;

   // Matrix buffer: one-cycle read latency, garbage when not strobed
   always @(posedge clock) begin
      if (weight_read_enable)
         weight_data <= VW'(w[weight_row[2:0]][weight_col[2:0]]);
      else
         weight_data <= VW'($urandom);
   end

   always @(posedge clock) begin
      if (weight_read_enable) begin
         vectors++;
         assert (int'(weight_row) < cur_n && int'(weight_col) < cur_n)
         else begin
            miscompares++;
            $error("FAIL rd_range observed=%0d,%0d expected below %0d",
                   weight_row, weight_col, cur_n);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input int src, input int n);
      bit vis [MN];
      for (int i = 0; i < MN; i++) begin
         exp_prev[i] = i;
         exp_dist[i] = INF;
         vis[i] = 1'b0;
      end
      if (n < 1 || n > MN || src >= n) return;
      exp_dist[src] = 0;
      for (int it = 0; it <= MN; it++) begin
         int u;
         int best;
         u = -1;
         best = INF;
         for (int i = 0; i < n; i++)
            if (!vis[i] && exp_dist[i] < best) begin
               best = exp_dist[i];
               u = i;
            end
         if (u < 0) break;
         vis[u] = 1'b1;
         for (int v = 0; v < n; v++) begin
            if (w[u][v] != 0 && !vis[v] && v != u) begin
               int c;
               c = exp_dist[u] + w[u][v];
               if (c < INF && c < exp_dist[v]) begin
                  exp_dist[v] = c;
                  exp_prev[v] = u;
               end
            end
         end
      end
   endtask

   task automatic clr_graph();
      for (int i = 0; i < MN; i++)
         for (int j = 0; j < MN; j++)
            w[i][j] = 0;
   endtask

   task automatic graph1();
      clr_graph();
      w[0][1] = 4;
      w[0][2] = 1;
      w[2][1] = 2;
      w[1][3] = 5;
   endtask

   task automatic chk_identity(input string tag);
      for (int i = 0; i < MN; i++)
         chk($sformatf("%s_prev%0d", tag, i), 32'(prev_vector[i]), i);
   endtask

   task automatic run(input int src, input int n, input string tag,
                      output int cyc);
      source_node = IW'(src);
      number_of_nodes = IW'(n);
      cur_n = n;
      model(src, n);
      enable = 1'b1;
      cyc = 0;
      while (cyc < 400) begin
         @(posedge clock);
         #1;
         cyc++;
         if (ready === 1'b1) break;
      end
      chk({tag, "_ready"}, 32'(ready), 1);
      if (n < 1 || n > MN || src >= n)
         chk({tag, "_lat"}, cyc, 2);
      else
         chk({tag, "_lat"}, 32'(cyc <= 2 + n * (2 * n + 1)), 1);
      chk({tag, "_rden"}, 32'(weight_read_enable), 0);
      for (int i = 0; i < MN; i++)
         chk($sformatf("%s_prev%0d", tag, i), 32'(prev_vector[i]),
             exp_prev[i]);
`ifdef DIJKSTRA_DIST_OUT_EN
      for (int i = 0; i < MN; i++)
         chk($sformatf("%s_dist%0d", tag, i), 32'(dist_vector[i]),
             exp_dist[i]);
`endif
   endtask

   task automatic stop();
      enable = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int cyc;
      bit found;
      reset = 1'b1;
      enable = 1'b0;
      source_node = '0;
      number_of_nodes = '0;
      clr_graph();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", 32'(ready), 0);
      chk("rst_rden", 32'(weight_read_enable), 0);
      chk("rst_row", 32'(weight_row), 0);
      chk("rst_col", 32'(weight_col), 0);
      chk_identity("rst");
      reset = 1'b0;
      @(posedge clock);
      #1;

      graph1();
      run(0, 4, "g1", cyc);
      chk("g1_p1_const", 32'(prev_vector[1]), 2);
      chk("g1_p3_const", 32'(prev_vector[3]), 1);
      stop();
      chk("g1_off_ready", 32'(ready), 0);
      chk_identity("g1_off");

      w[1][3] = 0;
      run(0, 4, "g2", cyc);
      chk("g2_p3_const", 32'(prev_vector[3]), 3);
      chk("g2_early", 32'(cyc < 2 + 4 * 9), 1);
      stop();

      clr_graph();
      w[0][1] = 2;
      w[0][2] = 1;
      w[2][1] = 1;
      run(0, 3, "tie", cyc);
      chk("tie_p1_const", 32'(prev_vector[1]), 0);
      stop();

      clr_graph();
      w[0][1] = 250;
      w[1][2] = 10;
      run(0, 3, "sat", cyc);
      chk("sat_p2_const", 32'(prev_vector[2]), 2);
      stop();

      graph1();
      source_node = '0;
      number_of_nodes = IW'(4);
      cur_n = 4;
      enable = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clock);
         #1;
         if (weight_read_enable && weight_row == 2) begin
            found = 1'b1;
            break;
         end
      end
      chk("abort_seen", 32'(found), 1);
      enable = 1'b0;
      @(posedge clock);
      #1;
      chk("abort_ready", 32'(ready), 0);
      chk("abort_rden", 32'(weight_read_enable), 0);
      chk_identity("abort");
      run(0, 4, "reen", cyc);
      stop();

      source_node = '0;
      number_of_nodes = IW'(4);
      enable = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clock);
         #1;
         if (weight_read_enable) begin
            found = 1'b1;
            break;
         end
      end
      chk("ar_seen", 32'(found), 1);
      repeat (6) @(posedge clock);
      #1;
      chk("ar_pre_p1", 32'(prev_vector[1]), 0);
      chk("ar_pre_rden", 32'(weight_read_enable), 0);
      #3;
      reset = 1'b1;
      #1;
      chk("ar_ready", 32'(ready), 0);
      chk("ar_rden", 32'(weight_read_enable), 0);
      chk("ar_row", 32'(weight_row), 0);
      chk_identity("ar");
      enable = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      run(5, 4, "err", cyc);
      stop();
      run(0, 0, "n0", cyc);
      stop();

      for (int t = 0; t < 20; t++) begin
         int n;
         int src;
         n = $urandom_range(1, MN);
         src = $urandom_range(0, n);
         for (int i = 0; i < MN; i++)
            for (int j = 0; j < MN; j++) begin
               if ($urandom_range(0, 9) < 4)
                  w[i][j] = ($urandom_range(0, 3) == 0)
                     ? $urandom_range(100, 255) : $urandom_range(1, 20);
               else
                  w[i][j] = 0;
            end
         run(src, n, $sformatf("rnd%0d", t), cyc);
         stop();
      end

      for (int i = 0; i < MN; i++)
         for (int j = 0; j < MN; j++)
            w[i][j] = $urandom_range(1, 30);
      run(3, MN, "dense", cyc);
      stop();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
